// File: rtl/alu_cmd_sequencer.sv
// Command front end for the combinational ALU: 2-entry command FIFO, registered
// ALU operand drive, result capture with architectural HI/LO, and a response handshake.
module alu_cmd_sequencer #(
    parameter logic [15:0] HILO_MASK = 16'h0018
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [15:0]        cmd_a,
    input  logic [15:0]        cmd_b,
    input  logic [3:0]         cmd_ins,
    output logic [15:0]        alu_a,
    output logic [15:0]        alu_b,
    output logic [3:0]         alu_ins,
    input  logic signed [15:0] alu_out,
    input  logic signed [15:0] alu_hi,
    input  logic signed [15:0] alu_lo,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [15:0]        rsp_out,
    output logic [15:0]        rsp_hi,
    output logic [15:0]        rsp_lo,
    output logic               rsp_err,
    output logic [15:0]        op_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    localparam logic [3:0] OP_MFHI = 4'd14;
    localparam logic [3:0] OP_MFLO = 4'd15;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_fifo_a   [2];
    logic [15:0] r_fifo_b   [2];
    logic [3:0]  r_fifo_ins [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_push;
    logic        w_pop;
    logic        w_capture;
    logic        w_rsp_hs;
    logic        w_empty;
    logic [3:0]  w_head_ins;

    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [3:0]  r_alu_ins;
    logic [3:0]  r_cur_ins;
    logic [15:0] r_hi;
    logic [15:0] r_lo;
    logic [15:0] r_rsp_out;
    logic [15:0] r_rsp_hi;
    logic [15:0] r_rsp_lo;
    logic        r_rsp_err;
    logic [15:0] r_op_count;

    function automatic logic is_alu_op(input logic [3:0] ins);
        return (ins >= 4'd1) && (ins <= 4'd9);
    endfunction

    function automatic logic writes_hilo(input logic [3:0] ins);
        return is_alu_op(ins) && HILO_MASK[ins];
    endfunction

    // No push-through: a full FIFO refuses even when the head pops this cycle.
    assign cmd_ready  = (r_count < 2'd2) && rst_n;
    assign w_push     = cmd_valid && cmd_ready;
    assign w_empty    = (r_count == 2'd0);
    assign w_head_ins = r_fifo_ins[r_rd_ptr];
    assign w_rsp_hs   = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_ISSUE;
            S_ISSUE: w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = w_empty ? S_IDLE : S_ISSUE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
            S_ISSUE: w_capture = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                w_pop     = rsp_ready && !w_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]   <= cmd_a;
            r_fifo_b[r_wr_ptr]   <= cmd_b;
            r_fifo_ins[r_wr_ptr] <= cmd_ins;
        end
    end

    // Pop -> ISSUE: only real ALU ops re-drive the ALU operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_ins <= '0;
            r_cur_ins <= '0;
        end else if (w_pop) begin
            r_cur_ins <= w_head_ins;
            if (is_alu_op(w_head_ins)) begin
                r_alu_a   <= r_fifo_a[r_rd_ptr];
                r_alu_b   <= r_fifo_b[r_rd_ptr];
                r_alu_ins <= w_head_ins;
            end
        end
    end

    // ISSUE -> RESP: capture result and commit HI/LO so later MF ops see it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_out <= '0;
            r_rsp_hi  <= '0;
            r_rsp_lo  <= '0;
            r_rsp_err <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_capture) begin
            if (is_alu_op(r_cur_ins)) begin
                r_rsp_out <= alu_out;
                r_rsp_hi  <= alu_hi;
                r_rsp_lo  <= alu_lo;
                r_rsp_err <= 1'b0;
                if (writes_hilo(r_cur_ins)) begin
                    r_hi <= alu_hi;
                    r_lo <= alu_lo;
                end
            end else if (r_cur_ins == OP_MFHI || r_cur_ins == OP_MFLO) begin
                r_rsp_out <= (r_cur_ins == OP_MFHI) ? r_hi : r_lo;
                r_rsp_hi  <= r_hi;
                r_rsp_lo  <= r_lo;
                r_rsp_err <= 1'b0;
            end else begin
                r_rsp_out <= '0;
                r_rsp_hi  <= '0;
                r_rsp_lo  <= '0;
                r_rsp_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_rsp_hs) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ins  = r_alu_ins;
    assign rsp_out  = r_rsp_out;
    assign rsp_hi   = r_rsp_hi;
    assign rsp_lo   = r_rsp_lo;
    assign rsp_err  = r_rsp_err;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed commands push hand-computed
// responses into a queue; a negedge monitor pops and compares each response.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_ins;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ins;
    logic [15:0] m_out;
    logic [15:0] m_hi;
    logic [15:0] m_lo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_out;
    logic [15:0] rsp_hi;
    logic [15:0] rsp_lo;
    logic        rsp_err;
    logic [15:0] op_count;

    typedef struct packed {
        logic [15:0] out;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    bit          gap_en = 1'b0;
    bit          have_last = 1'b0;
    int          last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_ins   (cmd_ins),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ins   (alu_ins),
        .alu_out   (m_out),
        .alu_hi    (m_hi),
        .alu_lo    (m_lo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    // Bench ALU: 1 add, 2 sub, 3 multiply (hi:lo), 4 divide (lo quotient, hi remainder).
    logic [31:0] m_prod;
    always_comb begin
        m_prod = {16'd0, alu_a} * {16'd0, alu_b};
        m_out  = 16'd0;
        m_hi   = 16'd0;
        m_lo   = 16'd0;
        case (alu_ins)
            4'd1: m_out = alu_a + alu_b;
            4'd2: m_out = alu_a - alu_b;
            4'd3: begin
                m_hi  = m_prod[31:16];
                m_lo  = m_prod[15:0];
                m_out = m_prod[15:0];
            end
            4'd4: if (alu_b != 16'd0) begin
                m_lo  = alu_a / alu_b;
                m_hi  = alu_a % alu_b;
                m_out = alu_a / alu_b;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got out=%0d with no response pending", rsp_out);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_out", rsp_out, e.out);
                chk("rsp_hi", rsp_hi, e.hi);
                chk("rsp_lo", rsp_lo, e.lo);
                chk("rsp_err", rsp_err, e.err);
                chk("op_count", op_count, exp_cnt);
            end
            if (gap_en) begin
                if (have_last) chk("rsp_gap", cyc - last_cyc, 2);
                last_cyc  = cyc;
                have_last = 1'b1;
            end
            exp_cnt = exp_cnt + 16'd1;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] ins,
                        input logic [15:0] eo, input logic [15:0] eh, input logic [15:0] el,
                        input logic ee);
        bit ok;
        rsp_t e;
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_ins   = ins;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (ok) begin
            e.out = eo;
            e.hi  = eh;
            e.lo  = el;
            e.err = ee;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("cmd_accept", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_out"}, rsp_out, 0);
        chk({tag, "_rsp_hi"}, rsp_hi, 0);
        chk({tag, "_rsp_lo"}, rsp_lo, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_ins"}, alu_ins, 0);
        chk({tag, "_op_count"}, op_count, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = 16'd0;
        cmd_b     = 16'd0;
        cmd_ins   = 4'd0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", cmd_ready, 1);
        @(posedge clk);
        #1;

        // Add with latency check: pop one edge after accept, response one edge later.
        send(16'd511, 16'd3, 4'd1, 16'd514, 16'd0, 16'd0, 1'b0);
        chk("lat_k_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_k1_valid", rsp_valid, 0);
        chk("issue_alu_a", alu_a, 511);
        chk("issue_alu_b", alu_b, 3);
        chk("issue_alu_ins", alu_ins, 1);
        @(posedge clk);
        #1;
        chk("lat_k2_valid", rsp_valid, 1);
        drain();
        chk("op_count_1", op_count, 1);

        // Multiply commits HI=0/LO=1533; MF ops read them back.
        send(16'd511, 16'd3, 4'd3, 16'd1533, 16'd0, 16'd1533, 1'b0);
        send(16'd0, 16'd0, 4'd15, 16'd1533, 16'd0, 16'd1533, 1'b0);
        send(16'd0, 16'd0, 4'd14, 16'd0, 16'd0, 16'd1533, 1'b0);
        drain();

        // Illegal opcodes zero the response and leave HI/LO alone.
        send(16'd7, 16'd9, 4'd0, 16'd0, 16'd0, 16'd0, 1'b1);
        send(16'd7, 16'd9, 4'd12, 16'd0, 16'd0, 16'd0, 1'b1);
        send(16'd0, 16'd0, 4'd15, 16'd1533, 16'd0, 16'd1533, 1'b0);
        chk("alu_a_held", alu_a, 511);
        chk("alu_ins_held", alu_ins, 3);
        drain();

        // Divide writes HI/LO; subtract (not in mask) does not.
        send(16'd100, 16'd7, 4'd4, 16'd14, 16'd2, 16'd14, 1'b0);
        send(16'd10, 16'd3, 4'd2, 16'd7, 16'd0, 16'd0, 1'b0);
        send(16'd0, 16'd0, 4'd14, 16'd2, 16'd2, 16'd14, 1'b0);
        send(16'd0, 16'd0, 4'd15, 16'd14, 16'd2, 16'd14, 1'b0);
        drain();

        // Backpressure: one in RESP plus two queued fills the FIFO.
        rsp_ready = 1'b0;
        send(16'd300, 16'd300, 4'd3, 16'd24464, 16'd1, 16'd24464, 1'b0);
        send(16'd0, 16'd0, 4'd14, 16'd1, 16'd1, 16'd24464, 1'b0);
        send(16'd0, 16'd0, 4'd15, 16'd24464, 16'd1, 16'd24464, 1'b0);
        chk("full_ready", cmd_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_ready", cmd_ready, 0);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_out", rsp_out, 24464);
        have_last = 1'b0;
        gap_en    = 1'b1;
        rsp_ready = 1'b1;
        drain();
        gap_en = 1'b0;

        // Reset while holding a response with two commands queued.
        rsp_ready = 1'b0;
        send(16'd100, 16'd7, 4'd4, 16'd14, 16'd2, 16'd14, 1'b0);
        send(16'd1, 16'd1, 4'd1, 16'd2, 16'd0, 16'd0, 1'b0);
        send(16'd5, 16'd1, 4'd2, 16'd4, 16'd0, 16'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", rsp_valid, 1);
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 16'd0;
        #1;
        check_zero("midreset");
        cmd_valid = 1'b1;
        cmd_a     = 16'd9;
        cmd_b     = 16'd9;
        cmd_ins   = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("no_stale_valid", rsp_valid, 0);
        end
        chk("post_reset_ready", cmd_ready, 1);
        send(16'd0, 16'd0, 4'd14, 16'd0, 16'd0, 16'd0, 1'b0);
        drain();
        chk("op_count_post_reset", op_count, 1);

        // op_count wrap from 16'hFFFF.
        force dut.r_op_count = 16'hFFFF;
        #1;
        release dut.r_op_count;
        exp_cnt = 16'hFFFF;
        send(16'd2, 16'd2, 4'd1, 16'd4, 16'd0, 16'd0, 1'b0);
        drain();
        chk("op_count_wrap", op_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential front end that feeds the combinational `alu`. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a 2-entry FIFO. For each command it drives the ALU's `A`/`B`/`ins` from registers, captures `out`/`hi`/`lo` one cycle later, and returns the result over a second valid/ready handshake. It also holds architectural HI/LO registers, read back with move-from opcodes, so it replaces the hand-written operand/opcode stimulus used when the ALU is exercised standalone.

## Interface
- `HILO_MASK`, default 16'h0018: bit n set means opcode n writes the HI/LO registers (default: opcodes 3 and 4).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the FIFO can accept a command.
- `cmd_a` input 16: operand A.
- `cmd_b` input 16: operand B.
- `cmd_ins` input 4: opcode.
- `alu_a` output 16: registered operand A to the ALU.
- `alu_b` output 16: registered operand B to the ALU.
- `alu_ins` output 4: registered opcode to the ALU.
- `alu_out` input 16 (signed): ALU result.
- `alu_hi` input 16 (signed): ALU high result.
- `alu_lo` input 16 (signed): ALU low result.
- `rsp_valid` output 1: a response is held.
- `rsp_ready` input 1: the consumer accepts the response.
- `rsp_out` output 16: response result.
- `rsp_hi` output 16: response high word.
- `rsp_lo` output 16: response low word.
- `rsp_err` output 1: the opcode was illegal.
- `op_count` output 16: count of completed responses; wraps from 16'hFFFF to 0.

## Operation
- Opcode classes:
  - 1–9: ALU ops.
  - 14: MFHI, returns HI on `rsp_out`.
  - 15: MFLO, returns LO on `rsp_out`.
  - 0 and 10–13: illegal; response has `rsp_out`/`rsp_hi`/`rsp_lo` = 0 and `rsp_err` = 1.
- FIFO: depth 2, in-order.
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready` = (count < 2) && `rst_n`.
  - When full, `cmd_ready` = 0 even if a pop occurs in the same cycle; there is no push-through.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE, FIFO non-empty: pop the head into `alu_a`/`alu_b`/`alu_ins`, go to ISSUE.
  - ISSUE: the ALU settles combinationally. At the next edge:
    - For ALU ops, capture `alu_out`/`alu_hi`/`alu_lo` into the `rsp_*` registers.
    - If `HILO_MASK[ins]` is set, also copy `alu_hi`/`alu_lo` into the HI/LO registers.
    - For MF ops, `rsp_out` = HI or LO, `rsp_hi` = HI, `rsp_lo` = LO.
    - Go to RESP and set `rsp_valid`.
  - RESP: hold `rsp_*` stable until `rsp_ready`. On the handshake edge:
    - Increment `op_count`.
    - If the FIFO is non-empty, pop directly into ISSUE; otherwise go to IDLE and clear `rsp_valid`.
- `alu_a`/`alu_b`/`alu_ins` hold their last values outside ISSUE. The ALU is not re-driven for MF or illegal ops; those still pass through ISSUE.
- HI/LO writes commit at ISSUE capture, so an MF command later in the FIFO sees the result of an earlier multiply/divide.
- Widths: all data is 16 bits, passed through with no extension or truncation.

## Timing
- Reset values (`rst_n` low): FIFO empty; FSM in IDLE; `cmd_ready` 0 while low and 1 after release.
  - Zero: `rsp_valid`, `rsp_out`, `rsp_hi`, `rsp_lo`, `rsp_err`, `alu_a`, `alu_b`, `alu_ins`, HI, LO, `op_count`.
- Reset mid-operation: the in-flight command, any held response and the FIFO contents are discarded, with no partial handshake. Commands presented while `rst_n` is low are ignored.
- Latency: a command accepted at edge k into an idle, empty block pops at k+1 and gives `rsp_valid` = 1 after k+2.
- Throughput: with `rsp_ready` held at 1, one response every 2 cycles.
- Backpressure: `rsp_ready` = 0 stalls in RESP. The FIFO fills to 2 and then `cmd_ready` drops.
- Simultaneous push and pop at count 1: count stays 1, order is preserved.

## Test plan
- Reset release, then a command with `cmd_a` = 511, `cmd_b` = 3, `cmd_ins` = 1 (bench ALU model: out = A+B) -> `rsp_valid` 2 edges after accept, `rsp_out` = 514, `rsp_err` = 0, `op_count` = 1.
- Command with `cmd_ins` = 3 (model: 511×3, hi = 0, lo = 1533), then `cmd_ins` = 15 -> second response has `rsp_out` = 1533; a following `cmd_ins` = 14 returns 0.
- `cmd_ins` = 0 and then `cmd_ins` = 12 -> each response has `rsp_err` = 1 and `rsp_out` = 0; HI/LO unchanged.
- `rsp_ready` = 0, push 3 commands -> `cmd_ready` drops after the 2nd queued command. Release `rsp_ready` -> all 3 responses come back in order, one every 2 cycles.
- Assert `rst_n` low while in RESP with 2 queued commands -> all outputs zero immediately. After release there are no stale responses and `cmd_ready` = 1.
- Preload `op_count` to 16'hFFFF through 65535 handshakes (or by force), then one more handshake -> `op_count` = 0.
